// File: rtl/fe_branch_predictor_pkg.sv
// Shared sizing, counter encodings and the saturating counter
// helper for the FE gshare predictor and its BTB.
package fe_branch_predictor_pkg;

    localparam int DBITS          = 32;
    localparam int BHR_BITS       = 8;
    localparam int PT_INDEX_BITS  = 8;
    localparam int BTB_INDEX_BITS = 4;
    localparam int TAG_BITS       = 26;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } ctr_e;

    localparam ctr_e PT_RESET = WNT;

    // Two-bit saturating step toward the resolved direction.
    function automatic logic [1:0] ctr_next(
        input logic [1:0] ctr,
        input logic       taken
    );
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && (ctr != ST)) begin
            nxt = ctr + 2'd1;
        end else if (!taken && (ctr != SNT)) begin
            nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/fe_branch_predictor_btb.sv
// Direct-mapped branch target buffer: one combinational read port,
// one synchronous write port, fully cleared on reset.
module bp_btb #(
    parameter int INDEX_BITS = 4,
    parameter int TAG_W      = 26,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_index,
    input  logic [TAG_W-1:0]      rd_tag,
    output logic                  rd_hit,
    output logic [DATA_W-1:0]     rd_target,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [DATA_W-1:0]     wr_target
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tags    [ENTRIES];
    logic [DATA_W-1:0]  targets [ENTRIES];

    always_comb begin
        rd_hit    = valid[rd_index] && (tags[rd_index] == rd_tag);
        rd_target = rd_hit ? targets[rd_index] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tags[i]    <= '0;
                targets[i] <= '0;
            end
        end else if (wr_en) begin
            valid[wr_index]   <= 1'b1;
            tags[wr_index]    <= wr_tag;
            targets[wr_index] <= wr_target;
        end
    end

endmodule

// File: rtl/fe_branch_predictor.sv
// Gshare direction predictor with a direct-mapped BTB for the FE stage,
// trained non-speculatively from AGEX branch resolution.
module fe_branch_predictor #(
    parameter int DBITS          = fe_branch_predictor_pkg::DBITS,
    parameter int BHR_BITS       = fe_branch_predictor_pkg::BHR_BITS,
    parameter int PT_INDEX_BITS  = fe_branch_predictor_pkg::PT_INDEX_BITS,
    parameter int BTB_INDEX_BITS = fe_branch_predictor_pkg::BTB_INDEX_BITS,
    parameter int TAG_BITS       = fe_branch_predictor_pkg::TAG_BITS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DBITS-1:0]         lookup_pc,
    output logic                     pred_btb_hit,
    output logic                     pred_taken,
    output logic [DBITS-1:0]         pred_target,
    output logic [DBITS-1:0]         pred_next_pc,
    output logic [PT_INDEX_BITS-1:0] pred_pt_index,
    input  logic                     upd_valid,
    input  logic [DBITS-1:0]         upd_pc,
    input  logic [PT_INDEX_BITS-1:0] upd_pt_index,
    input  logic                     upd_taken,
    input  logic [DBITS-1:0]         upd_target,
    input  logic                     upd_pred_taken,
    input  logic [DBITS-1:0]         upd_pred_target,
    output logic                     upd_mispredict,
    output logic [31:0]              branch_count,
    output logic [31:0]              correct_count
);

    import fe_branch_predictor_pkg::*;

    localparam int PT_ENTRIES = 1 << PT_INDEX_BITS;

    logic [1:0]               pt [PT_ENTRIES];
    logic [BHR_BITS-1:0]      bhr;

    logic [BTB_INDEX_BITS-1:0] lk_btb_idx;
    logic [TAG_BITS-1:0]       lk_tag;
    logic [PT_INDEX_BITS-1:0]  lk_pt_idx;
    logic                      btb_hit;
    logic [DBITS-1:0]          btb_target;

    logic                      upd_correct;
    logic                      btb_wr_en;
    logic [BTB_INDEX_BITS-1:0] upd_btb_idx;
    logic [TAG_BITS-1:0]       upd_tag;

    // Byte-offset bits carry no information for 4-byte instructions.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lk_btb_idx = lookup_pc[BTB_INDEX_BITS+1:2];
    assign lk_tag     = lookup_pc[DBITS-1:DBITS-TAG_BITS];
    assign lk_pt_idx  = lookup_pc[PT_INDEX_BITS+1:2]
                      ^ PT_INDEX_BITS'(bhr);

    bp_btb #(
        .INDEX_BITS (BTB_INDEX_BITS),
        .TAG_W      (TAG_BITS),
        .DATA_W     (DBITS)
    ) u_btb (
        .clk       (clk),
        .reset     (reset),
        .rd_index  (lk_btb_idx),
        .rd_tag    (lk_tag),
        .rd_hit    (btb_hit),
        .rd_target (btb_target),
        .wr_en     (btb_wr_en),
        .wr_index  (upd_btb_idx),
        .wr_tag    (upd_tag),
        .wr_target (upd_target)
    );

    always_comb begin
        pred_btb_hit  = btb_hit;
        pred_target   = btb_target;
        pred_pt_index = lk_pt_idx;
        pred_taken    = btb_hit && (pt[lk_pt_idx] >= WT);
        pred_next_pc  = pred_taken ? btb_target
                                   : lookup_pc + DBITS'(4);
    end

    // Target only matters when the branch actually went taken.
    assign upd_correct = (upd_pred_taken == upd_taken)
                      && (!upd_taken || (upd_pred_target == upd_target));
    assign upd_mispredict = upd_valid && !upd_correct;

    assign upd_btb_idx = upd_pc[BTB_INDEX_BITS+1:2];
    assign upd_tag     = upd_pc[DBITS-1:DBITS-TAG_BITS];
    assign btb_wr_en   = upd_valid && upd_taken && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PT_ENTRIES; i++) begin
                pt[i] <= PT_RESET;
            end
            bhr           <= '0;
            branch_count  <= '0;
            correct_count <= '0;
        end else if (upd_valid) begin
            pt[upd_pt_index] <= ctr_next(pt[upd_pt_index], upd_taken);
            bhr              <= {bhr[BHR_BITS-2:0], upd_taken};
            branch_count     <= branch_count + 32'd1;
            if (upd_correct) begin
                correct_count <= correct_count + 32'd1;
            end
        end
    end

endmodule
